// File: rtl/cla_pkg.sv
// Shared constants and FSM state type for the word-serial CLA adder.
package cla_pkg;

  localparam int unsigned SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla5_slice.sv
// Combinational 5-bit carry-lookahead slice; exposes the carry into bit 4 for overflow detection.
module cla5_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               c4,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Every carry is a flat sum of generate/propagate products.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[SLICE_W-1:0];
    c4   = c[4];
    cout = c[5];
  end

endmodule

// File: rtl/cla_serial_wide_adder.sv
// Word-serial wide adder: one 5-bit CLA slice per cycle, LSB slice first, valid/ready on both sides.
// Optional subtract mode (in_sub port) is enabled by defining CLA_SER_SUB_EN.
module cla_serial_wide_adder
  import cla_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
`ifdef CLA_SER_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int unsigned W     = SLICE_W * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic [SLICE_W-1:0] a_s, b_s, s_sum;
  logic               s_c4, s_cout;
  logic               sub_sel;

`ifdef CLA_SER_SUB_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  cla5_slice u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry_q),
    .sum  (s_sum),
    .c4   (s_c4),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    ready_d = ready_q;
    a_s     = '0;
    b_s     = '0;

    // Steer the current slice of the latched operands into the single CLA instance.
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_s = a_q[i*SLICE_W +: SLICE_W];
        b_s = b_q[i*SLICE_W +: SLICE_W];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = sub_sel ? ~in_b : in_b;
          carry_d = sub_sel ? 1'b1 : in_cin;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*SLICE_W +: SLICE_W] = s_sum;
          end
        end
        carry_d = s_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WORDS - 1)) begin
          cout_d  = s_cout;
          ovf_d   = s_c4 ^ s_cout;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_serial_wide_adder.sv
// Directed, table-driven bench for cla_serial_wide_adder at WORDS=4 (20-bit operands).
module tb_cla_serial_wide_adder;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 5 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
`ifdef CLA_SER_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_cmp;
  int n_fail;

  cla_serial_wide_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, scramble inputs, then count edges until out_valid.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output int lat);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef CLA_SER_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract requested without subtract build");
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = ~cin;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int           lat;
    logic [W-1:0] held;
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
`ifdef CLA_SER_SUB_EN
    in_sub    = 1'b0;
`endif

    vecs[0] = '{a: 20'd22,    b: 20'd13,    cin: 1'b0, sum: 20'd35,    cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 20'hFFFFF, b: 20'h00001, cin: 1'b0, sum: 20'h00000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 20'h7FFFF, b: 20'h00001, cin: 1'b0, sum: 20'h80000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 20'd15,    b: 20'd23,    cin: 1'b1, sum: 20'd39,    cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 20'h80000, b: 20'h80000, cin: 1'b0, sum: 20'h00000, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 20'hAAAAA, b: 20'h55555, cin: 1'b1, sum: 20'h00000, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 20'h12345, b: 20'h0ABCD, cin: 1'b0, sum: 20'h1CF12, cout: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 20'h40000, b: 20'h40000, cin: 1'b0, sum: 20'h80000, cout: 1'b0, ovf: 1'b1};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(WORDS));
      chk($sformatf("v%0d_sum", i), 32'(out_sum), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(out_cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
      drain();
      chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result holds under out_ready=0, stray in_valid ignored.
    start_op(20'd100, 20'd200, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'(WORDS));
    held = out_sum;
    chk("bp_sum", 32'(held), 32'd300);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        in_a = 20'h11111; in_b = 20'h22222; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_stable_c%0d", c), 32'(out_sum), 32'(held));
      chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_single_transfer", 32'(out_valid), 32'd0);

    // Reset abandons an operation two slices in.
    in_a = 20'hFFFFF; in_b = 20'hFFFFF; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_valid", 32'(out_valid), 32'd0);
    chk("midrun_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_op(20'd15, 20'd23, 1'b0, 1'b0, lat);
    chk("postrst_latency", 32'(lat), 32'(WORDS));
    chk("postrst_sum", 32'(out_sum), 32'd38);
    chk("postrst_cout", 32'(out_cout), 32'd0);
    drain();

`ifdef CLA_SER_SUB_EN
    start_op(20'd13, 20'd22, 1'b1, 1'b1, lat);
    chk("sub1_sum", 32'(out_sum), 32'h000FFFF7);
    chk("sub1_cout", 32'(out_cout), 32'd0);
    chk("sub1_ovf", 32'(out_ovf), 32'd0);
    drain();
    start_op(20'd22, 20'd13, 1'b0, 1'b1, lat);
    chk("sub2_sum", 32'(out_sum), 32'd9);
    chk("sub2_cout", 32'(out_cout), 32'd1);
    drain();
    start_op(20'd22, 20'd13, 1'b0, 1'b0, lat);
    chk("sub_off_sum", 32'(out_sum), 32'd35);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
